// File: rtl/cpl_enqueue_client.sv
// Completion enqueue client: takes one completion record at a time through
// request / response / host write / write-done / commit. Optional write-done
// watchdog is enabled by defining CPL_ENQUEUE_CLIENT_TIMEOUT_EN.
module cpl_enqueue_client #(
  parameter int unsigned QUEUE_INDEX_WIDTH = 8,
  parameter int unsigned REQ_TAG_WIDTH     = 8,
  parameter int unsigned OP_TAG_WIDTH      = 4,
  parameter int unsigned ADDR_WIDTH        = 64,
  parameter int unsigned CPL_WIDTH         = 128,
  parameter int unsigned TIMEOUT_CYCLES    = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [QUEUE_INDEX_WIDTH-1:0] s_axis_cpl_queue,
  input  logic [CPL_WIDTH-1:0]         s_axis_cpl_data,
  input  logic                         s_axis_cpl_valid,
  output logic                         s_axis_cpl_ready,
  output logic [QUEUE_INDEX_WIDTH-1:0] m_axis_enqueue_req_queue,
  output logic [REQ_TAG_WIDTH-1:0]     m_axis_enqueue_req_tag,
  output logic                         m_axis_enqueue_req_valid,
  input  logic                         m_axis_enqueue_req_ready,
  input  logic [ADDR_WIDTH-1:0]        s_axis_enqueue_resp_addr,
  input  logic [REQ_TAG_WIDTH-1:0]     s_axis_enqueue_resp_tag,
  input  logic [OP_TAG_WIDTH-1:0]      s_axis_enqueue_resp_op_tag,
  input  logic                         s_axis_enqueue_resp_full,
  input  logic                         s_axis_enqueue_resp_error,
  input  logic                         s_axis_enqueue_resp_valid,
  output logic                         s_axis_enqueue_resp_ready,
  output logic [OP_TAG_WIDTH-1:0]      m_axis_enqueue_commit_op_tag,
  output logic                         m_axis_enqueue_commit_valid,
  input  logic                         m_axis_enqueue_commit_ready,
  output logic [ADDR_WIDTH-1:0]        m_axis_wr_addr,
  output logic [CPL_WIDTH-1:0]         m_axis_wr_data,
  output logic                         m_axis_wr_valid,
  input  logic                         m_axis_wr_ready,
  input  logic                         s_axis_wr_done_valid,
  output logic [31:0]                  stat_drop_count,
  output logic                         stat_timeout,
  output logic                         busy
);

  localparam int unsigned STAT_WIDTH = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
    S_WRITE,
    S_WAIT_DONE,
    S_COMMIT
  } state_e;

  state_e                       state_q, state_d;
  logic                         cpl_ready_q, cpl_ready_d;
  logic                         req_valid_q, req_valid_d;
  logic                         resp_ready_q, resp_ready_d;
  logic                         wr_valid_q, wr_valid_d;
  logic                         commit_valid_q, commit_valid_d;
  logic                         busy_q, busy_d;
  logic [QUEUE_INDEX_WIDTH-1:0] queue_q, queue_d;
  logic [CPL_WIDTH-1:0]         data_q, data_d;
  logic [ADDR_WIDTH-1:0]        addr_q, addr_d;
  logic [OP_TAG_WIDTH-1:0]      op_tag_q, op_tag_d;
  logic [REQ_TAG_WIDTH-1:0]     tag_q, tag_d;
  logic [REQ_TAG_WIDTH-1:0]     issued_tag_q, issued_tag_d;
  logic [STAT_WIDTH-1:0]        drop_q, drop_d;

`ifdef CPL_ENQUEUE_CLIENT_TIMEOUT_EN
  localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_WIDTH-1:0] wd_cnt_q, wd_cnt_d;
  logic                 timeout_q, timeout_d;
`endif

  // Next-state, datapath latches and registered handshake outputs
  always_comb begin
    state_d      = state_q;
    queue_d      = queue_q;
    data_d       = data_q;
    addr_d       = addr_q;
    op_tag_d     = op_tag_q;
    tag_d        = tag_q;
    issued_tag_d = issued_tag_q;
    drop_d       = drop_q;
`ifdef CPL_ENQUEUE_CLIENT_TIMEOUT_EN
    wd_cnt_d     = wd_cnt_q;
    timeout_d    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (s_axis_cpl_valid && cpl_ready_q) begin
          queue_d = s_axis_cpl_queue;
          data_d  = s_axis_cpl_data;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (req_valid_q && m_axis_enqueue_req_ready) begin
          issued_tag_d = tag_q;
          tag_d        = tag_q + REQ_TAG_WIDTH'(1);
          state_d      = S_RESP;
        end
      end
      S_RESP: begin
        // Responses carrying a foreign tag are consumed and dropped
        if (s_axis_enqueue_resp_valid && resp_ready_q &&
            (s_axis_enqueue_resp_tag == issued_tag_q)) begin
          if (s_axis_enqueue_resp_full || s_axis_enqueue_resp_error) begin
            if (drop_q != {STAT_WIDTH{1'b1}}) drop_d = drop_q + STAT_WIDTH'(1);
            state_d = S_IDLE;
          end else begin
            addr_d   = s_axis_enqueue_resp_addr;
            op_tag_d = s_axis_enqueue_resp_op_tag;
            state_d  = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (wr_valid_q && m_axis_wr_ready) begin
          state_d = S_WAIT_DONE;
`ifdef CPL_ENQUEUE_CLIENT_TIMEOUT_EN
          wd_cnt_d = '0;
`endif
        end
      end
      S_WAIT_DONE: begin
`ifdef CPL_ENQUEUE_CLIENT_TIMEOUT_EN
        wd_cnt_d = wd_cnt_q + CNT_WIDTH'(1);
        if (s_axis_wr_done_valid) begin
          state_d = S_COMMIT;
        end else if (wd_cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
          state_d   = S_COMMIT;
          timeout_d = 1'b1;
        end
`else
        if (s_axis_wr_done_valid) state_d = S_COMMIT;
`endif
      end
      S_COMMIT: begin
        if (commit_valid_q && m_axis_enqueue_commit_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    cpl_ready_d    = (state_d == S_IDLE);
    req_valid_d    = (state_d == S_REQ);
    resp_ready_d   = (state_d == S_RESP);
    wr_valid_d     = (state_d == S_WRITE);
    commit_valid_d = (state_d == S_COMMIT);
    busy_d         = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      cpl_ready_q    <= 1'b1;
      req_valid_q    <= 1'b0;
      resp_ready_q   <= 1'b0;
      wr_valid_q     <= 1'b0;
      commit_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      queue_q        <= '0;
      data_q         <= '0;
      addr_q         <= '0;
      op_tag_q       <= '0;
      tag_q          <= '0;
      issued_tag_q   <= '0;
      drop_q         <= '0;
`ifdef CPL_ENQUEUE_CLIENT_TIMEOUT_EN
      wd_cnt_q       <= '0;
      timeout_q      <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      cpl_ready_q    <= cpl_ready_d;
      req_valid_q    <= req_valid_d;
      resp_ready_q   <= resp_ready_d;
      wr_valid_q     <= wr_valid_d;
      commit_valid_q <= commit_valid_d;
      busy_q         <= busy_d;
      queue_q        <= queue_d;
      data_q         <= data_d;
      addr_q         <= addr_d;
      op_tag_q       <= op_tag_d;
      tag_q          <= tag_d;
      issued_tag_q   <= issued_tag_d;
      drop_q         <= drop_d;
`ifdef CPL_ENQUEUE_CLIENT_TIMEOUT_EN
      wd_cnt_q       <= wd_cnt_d;
      timeout_q      <= timeout_d;
`endif
    end
  end

  assign s_axis_cpl_ready             = cpl_ready_q;
  assign m_axis_enqueue_req_queue     = queue_q;
  assign m_axis_enqueue_req_tag       = tag_q;
  assign m_axis_enqueue_req_valid     = req_valid_q;
  assign s_axis_enqueue_resp_ready    = resp_ready_q;
  assign m_axis_enqueue_commit_op_tag = op_tag_q;
  assign m_axis_enqueue_commit_valid  = commit_valid_q;
  assign m_axis_wr_addr               = addr_q;
  assign m_axis_wr_data               = data_q;
  assign m_axis_wr_valid              = wr_valid_q;
  assign stat_drop_count              = drop_q;
  assign busy                         = busy_q;

`ifdef CPL_ENQUEUE_CLIENT_TIMEOUT_EN
  assign stat_timeout = timeout_q;
`else
  // Without the watchdog the limit parameter has no consumer
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^32'(TIMEOUT_CYCLES);
  assign stat_timeout          = 1'b0;
`endif

endmodule
